// File: rtl/simplerisc_pipe_pkg.sv
// Shared types for the SimpleRISC pipeline control: FSM states, register index width,
// and the packed stall/flush bundle driven onto the pipe registers.
package simplerisc_pipe_pkg;

  localparam int REG_W = 5;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic pc;
    logic ifof;
    logic ofalu;
    logic aluma;
    logic marw;
  } stall_t;

  typedef struct packed {
    logic ifof;
    logic ofalu;
    logic aluma;
    logic marw;
  } flush_t;

  typedef struct packed {
    stall_t stall;
    flush_t flush;
    logic   mc_busy;
  } hz_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_perf_ctr.sv
// Two free-running wrap-around event counters with enables; one cycle update latency,
// synchronous reset clears both, no backpressure.
module pipe_ctrl_perf_ctr #(
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_en,
  input  logic             flush_en,
  output logic [CTR_W-1:0] stall_cycles,
  output logic [CTR_W-1:0] flush_events
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_en) stall_cycles <= stall_cycles + CTR_W'(1);
      if (flush_en) flush_events <= flush_events + CTR_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe; controls respond combinationally in the same
// cycle, only the multicycle FSM and the perf counters are registered.
module pipe_hazard_ctrl
  import simplerisc_pipe_pkg::*;
#(
  parameter int MC_LAT   = 4,
  parameter int LDST_FWD = 1,
  parameter int CTR_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             is_Ld_ALU,
  input  logic             isWb_ALU,
  input  logic [REG_W-1:0] rd_ALU,
  input  logic [REG_W-1:0] RP1_OF,
  input  logic [REG_W-1:0] RP2_OF,
  input  logic             use1_OF,
  input  logic             use2_OF,
  input  logic             is_St_OF,
  input  logic             branch_taken_ALU,
  input  logic             mc_op_ALU,
  input  logic             mem_wait,
  output logic             stall_PC,
  output logic             stall_IFOF,
  output logic             stall_OFALU,
  output logic             stall_ALUMA,
  output logic             stall_MARW,
  output logic             flush_IFOF,
  output logic             flush_OFALU,
  output logic             flush_ALUMA,
  output logic             flush_MARW,
  output logic             mc_busy,
  output logic [CTR_W-1:0] stall_cycles,
  output logic [CTR_W-1:0] flush_events
);

  localparam int CNT_W = $clog2(MC_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 2);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  hz_ctrl_t         ctl;
  logic             src1_hit, src2_hit, load_use;
  logic             mc_stalling, mc_release;

  assign src1_hit = use1_OF && (RP1_OF == rd_ALU);
  assign src2_hit = use2_OF && (RP2_OF == rd_ALU);
  // A load that only supplies store data can be forwarded at MA, so it need not stall.
  assign load_use = is_Ld_ALU && isWb_ALU &&
                    (src1_hit || (src2_hit && !((LDST_FWD != 0) && is_St_OF)));

  assign mc_stalling = (state == MC_BUSY) && (cnt != '0);
  assign mc_release  = (state == MC_BUSY) && (cnt == '0);

  always_comb begin
    ctl     = '0;
    state_n = state;
    cnt_n   = cnt;
    if (rst) begin
      ctl.flush = '1;
      state_n   = RUN;
      cnt_n     = '0;
    end else if (mem_wait) begin
      ctl.stall.pc    = 1'b1;
      ctl.stall.ifof  = 1'b1;
      ctl.stall.ofalu = 1'b1;
      ctl.stall.aluma = 1'b1;
      ctl.flush.marw  = 1'b1;
    end else if (mc_stalling) begin
      ctl.stall.pc    = 1'b1;
      ctl.stall.ifof  = 1'b1;
      ctl.stall.ofalu = 1'b1;
      ctl.flush.aluma = 1'b1;
      ctl.mc_busy     = 1'b1;
      cnt_n           = cnt - CNT_W'(1);
    end else begin
      if (mc_release) state_n = RUN;
      // The release cycle must not retrigger on the same, still-present mc op.
      if ((state == RUN) && mc_op_ALU) begin
        ctl.stall.pc    = 1'b1;
        ctl.stall.ifof  = 1'b1;
        ctl.stall.ofalu = 1'b1;
        ctl.flush.aluma = 1'b1;
        ctl.mc_busy     = 1'b1;
        state_n         = MC_BUSY;
        cnt_n           = CNT_INIT;
      end else if (branch_taken_ALU) begin
        ctl.flush.ifof  = 1'b1;
        ctl.flush.ofalu = 1'b1;
      end else if (load_use) begin
        ctl.stall.pc    = 1'b1;
        ctl.stall.ifof  = 1'b1;
        ctl.flush.ofalu = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  assign stall_PC    = ctl.stall.pc;
  assign stall_IFOF  = ctl.stall.ifof;
  assign stall_OFALU = ctl.stall.ofalu;
  assign stall_ALUMA = ctl.stall.aluma;
  assign stall_MARW  = ctl.stall.marw;
  assign flush_IFOF  = ctl.flush.ifof;
  assign flush_OFALU = ctl.flush.ofalu;
  assign flush_ALUMA = ctl.flush.aluma;
  assign flush_MARW  = ctl.flush.marw;
  assign mc_busy     = ctl.mc_busy;

  pipe_ctrl_perf_ctr #(
    .CTR_W(CTR_W)
  ) u_perf (
    .clk         (clk),
    .rst         (rst),
    .stall_en    (ctl.stall.pc),
    .flush_en    (ctl.flush.ifof || ctl.flush.ofalu),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

endmodule
